// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access.
// Requests are granted combinationally, with a lock that holds a stalled winner.
// Responses are routed back in order using a 1-bit source FIFO.
module mem_port_arbiter #(
   parameter int unsigned MAX_OUTST    = 4,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int unsigned PtrW = $clog2(MAX_OUTST);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {StIdle, StLockI, StLockD} lock_e;

   lock_e                lock_q, lock_d;
   logic [StvW-1:0]      starve_q, starve_d;
   logic [MAX_OUTST-1:0] fifo_q;
   logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]      count_q, count_d;

   logic grant_data;
   logic full;
   logic accept;
   logic pop;
   logic head;

   // Winner selection: a locked requester keeps the port, otherwise data wins unless inst starves.
   always_comb begin
      grant_data = 1'b0;
      unique case (lock_q)
         StLockI: grant_data = 1'b0;
         StLockD: grant_data = 1'b1;
         default: grant_data = data_req && !(inst_req && (starve_q == StvW'(STARVE_LIMIT)));
      endcase
   end

   assign full   = (count_q == CntW'(MAX_OUTST));
   // resetn gating keeps the port quiet while reset is held.
   assign mem_req = resetn && !full && ((lock_q != StIdle) || inst_req || data_req);
   assign accept  = mem_req && mem_addr_ok;

   assign inst_addr_ok = accept && !grant_data;
   assign data_addr_ok = accept && grant_data;

   // Forward the winner's payload; fetches are always word reads.
   always_comb begin
      mem_wr    = 1'b0;
      mem_size  = 2'd2;
      mem_wstrb = 4'h0;
      mem_addr  = inst_addr;
      mem_wdata = 32'h0;
      if (grant_data) begin
         mem_wr    = data_wr;
         mem_size  = data_size;
         mem_wstrb = data_wstrb;
         mem_addr  = data_addr;
         mem_wdata = data_wdata;
      end
   end

   // Stray responses with nothing outstanding are dropped.
   assign pop  = mem_data_ok && (count_q != '0);
   assign head = fifo_q[rd_ptr_q];

   assign inst_data_ok = pop && !head;
   assign data_data_ok = pop && head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   // Lock, starvation and occupancy next-state.
   always_comb begin
      lock_d   = lock_q;
      starve_d = starve_q;
      count_d  = count_q;
      if (mem_req) begin
         if (mem_addr_ok) begin
            lock_d = StIdle;
         end else begin
            lock_d = grant_data ? StLockD : StLockI;
         end
      end
      if (!inst_req || inst_addr_ok) begin
         starve_d = '0;
      end else if (data_addr_ok && (starve_q != StvW'(STARVE_LIMIT))) begin
         starve_d = starve_q + StvW'(1);
      end
      unique case ({accept, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // State registers and order FIFO storage.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_q   <= StIdle;
         starve_q <= '0;
         count_q  <= '0;
         fifo_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         lock_q   <= lock_d;
         starve_q <= starve_d;
         count_q  <= count_d;
         if (accept) begin
            fifo_q[wr_ptr_q] <= grant_data;
            wr_ptr_q         <= wr_ptr_q + PtrW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
      end
   end

endmodule
